// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit and its programmer/decoder side.
// Carries the programming port, decoder branch request and run status.
interface instr_fetch_unit_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int LUT_AW  = 5,
    parameter int CNT_W   = 16
);
    logic               start;
    logic               prog_we;
    logic [PC_W-1:0]    prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               lut_we;
    logic [LUT_AW-1:0]  lut_addr;
    logic [PC_W-1:0]    lut_data;
    logic               branch_enable;
    logic [LUT_AW-1:0]  branch_lut_index;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic               running;
    logic               done;
    logic               pc_overflow;
    logic [CNT_W-1:0]   cycle_count;

    modport slave (
        input  start,
        input  prog_we,
        input  prog_addr,
        input  prog_data,
        input  lut_we,
        input  lut_addr,
        input  lut_data,
        input  branch_enable,
        input  branch_lut_index,
        output instr,
        output instr_valid,
        output pc,
        output running,
        output done,
        output pc_overflow,
        output cycle_count
    );

    modport master (
        output start,
        output prog_we,
        output prog_addr,
        output prog_data,
        output lut_we,
        output lut_addr,
        output lut_data,
        output branch_enable,
        output branch_lut_index,
        input  instr,
        input  instr_valid,
        input  pc,
        input  running,
        input  done,
        input  pc_overflow,
        input  cycle_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC sequencer and instruction fetch for the 9-bit core.
// Owns instruction memory and branch-target LUT; runs IDLE -> RUN -> DONE.
module instr_fetch_unit #(
    parameter int                 PC_W      = 10,
    parameter int                 INSTR_W   = 9,
    parameter int                 LUT_AW    = 5,
    parameter logic [INSTR_W-1:0] HALT_WORD = 9'b011110000,
    parameter int                 CNT_W     = 16
) (
    input logic clk,
    input logic reset,
    instr_fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    logic [INSTR_W-1:0] r_imem [2**PC_W];
    logic [PC_W-1:0]    r_lut  [2**LUT_AW];

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;

    logic [INSTR_W-1:0] w_instr;
    logic               w_prog_ok;
    logic               w_halt;
    logic               w_pc_last;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_instr   = r_imem[r_pc];
    assign w_prog_ok = (r_state != S_RUN);
    assign w_halt    = (w_instr == HALT_WORD);
    assign w_pc_last = &r_pc;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    // Storage is never reset; the port is locked out while a run is live.
    always_ff @(posedge clk) begin
        if (bus.prog_we && w_prog_ok) begin
            r_imem[bus.prog_addr] <= bus.prog_data;
        end
        if (bus.lut_we && w_prog_ok) begin
            r_lut[bus.lut_addr] <= bus.lut_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            S_RUN: begin
                w_cnt_nxt = w_cnt_inc;
                // Halt outranks a branch request on the same word.
                if (w_halt) begin
                    w_state_nxt = S_DONE;
                end else if (bus.branch_enable) begin
                    w_pc_nxt = r_lut[bus.branch_lut_index];
                end else if (w_pc_last) begin
                    w_state_nxt = S_DONE;
                    w_ovf_nxt   = 1'b1;
                end else begin
                    w_pc_nxt = r_pc + PC_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.instr       = w_instr;
    assign bus.instr_valid = (r_state == S_RUN);
    assign bus.pc          = r_pc;
    assign bus.running     = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.pc_overflow = r_ovf;
    assign bus.cycle_count = r_cnt;

endmodule
